ysyx_24100006_inst_encoder: RTL and testbench

//  Inverse of the ID-stage immediate extractor: packs opcode/register/funct fields and a 32-bit

---
 rtl/ysyx_24100006_inst_encoder.sv | 140 ++++++++++++++
 tb/tb_ysyx_24100006_inst_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_inst_encoder.sv
// RV32 instruction encoder: packs fields and an immediate into an instruction
// word per immediate type, buffered through a small output FIFO.
module ysyx_24100006_inst_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       Imm_Type,
  input  logic [31:0]      imm,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic        isI;
  logic        isJ;
  logic        isS;
  logic        isB;
  logic        isU;
  logic        fitsI;
  logic        fitsB;
  logic        fitsJ;
  logic        alignU;
  logic [31:0] encInst;
  logic        encErr;

  assign isI = (Imm_Type == 3'b000);
  assign isJ = (Imm_Type == 3'b001);
  assign isS = (Imm_Type == 3'b010);
  assign isB = (Imm_Type == 3'b011);
  assign isU = (Imm_Type == 3'b100);

  // Each range check asks whether the upper bits are a pure sign extension.
  assign fitsI  = (&imm[31:11]) | ~(|imm[31:11]);
  assign fitsB  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign fitsJ  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign alignU = ~(|imm[11:0]);

  always_comb begin
    encInst = 32'h0;
    encErr  = 1'b1;
    unique case (1'b1)
      isI: begin
        encInst = {imm[11:0], rs1, funct3, rd, opcode};
        encErr  = ~fitsI;
      end
      isS: begin
        encInst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        encErr  = ~fitsI;
      end
      isB: begin
        encInst = {imm[12], imm[10:5], rs2, rs1, funct3,
                   imm[4:1], imm[11], opcode};
        encErr  = ~fitsB;
      end
      isJ: begin
        encInst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        encErr  = ~fitsJ;
      end
      isU: begin
        encInst = {imm[31:12], rd, opcode};
        encErr  = ~alignU;
      end
      default: begin
        encInst = 32'h0;
        encErr  = 1'b1;
      end
    endcase
  end

  logic [31:0]      memInst [DEPTH];
  logic             memErr  [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [OCC_W-1:0] occ;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full     = (occ == OCC_FULL);
  assign empty    = (occ == '0);
  // Readiness depends only on occupancy, so a pop never frees a slot early.
  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign pop      = out_ready & ~empty;

  assign out_valid = ~empty;
  assign out_inst  = empty ? 32'h0 : memInst[rdPtr];
  assign out_err   = empty ? 1'b0 : memErr[rdPtr];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        memInst[i] <= 32'h0;
        memErr[i]  <= 1'b0;
      end
      wrPtr <= '0;
      rdPtr <= '0;
      occ   <= '0;
    end else begin
      if (push) begin
        memInst[wrPtr] <= encInst;
        memErr[wrPtr]  <= encErr;
        wrPtr          <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (push && encErr && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_inst_encoder.sv
// Bench for the instruction encoder: directed cases then randomized traffic
// checked against a queue-based reference model.
module tb_ysyx_24100006_inst_encoder;

  localparam int DEPTH = 2;
  localparam int CW    = 4;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    Imm_Type;
  logic [31:0]   imm;
  logic [6:0]    opcode;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [2:0]    funct3;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic          out_err;
  logic [CW-1:0] err_cnt;

  ysyx_24100006_inst_encoder #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .Imm_Type(Imm_Type), .imm(imm), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .err_cnt(err_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } ent_t;

  ent_t q[$];
  int   errM;
  int   tests;
  int   fails;

  function automatic ent_t refEnc();
    ent_t e;
    int   si;
    si = imm;
    e.inst = 32'h0;
    e.err  = 1'b1;
    case (Imm_Type)
      3'd0: begin
        e.inst = {imm[11:0], rs1, funct3, rd, opcode};
        e.err  = (si < -2048) || (si > 2047);
      end
      3'd2: begin
        e.inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        e.err  = (si < -2048) || (si > 2047);
      end
      3'd3: begin
        e.inst = {imm[12], imm[10:5], rs2, rs1, funct3,
                  imm[4:1], imm[11], opcode};
        e.err  = (si < -4096) || (si > 4094) || (si % 2 != 0);
      end
      3'd1: begin
        e.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        e.err  = (si < -(1 << 20)) || (si > (1 << 20) - 2) || (si % 2 != 0);
      end
      3'd4: begin
        e.inst = {imm[31:12], rd, opcode};
        e.err  = (imm % 4096) != 0;
      end
      default: begin
        e.inst = 32'h0;
        e.err  = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    ent_t h;
    h.inst = 32'h0;
    h.err  = 1'b0;
    if (q.size() > 0) h = q[0];
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    chk("out_inst", out_inst, h.inst);
    chk("out_err", {31'b0, out_err}, {31'b0, h.err});
    chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < DEPTH});
    chk("err_cnt", {{(32-CW){1'b0}}, err_cnt}, errM);
  endtask

  task automatic step();
    bit   acc;
    bit   pp;
    ent_t e;
    acc = in_valid && (q.size() < DEPTH);
    pp  = out_ready && (q.size() > 0);
    e   = refEnc();
    @(posedge clock);
    if (reset) begin
      q.delete();
      errM = 0;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (e.err && errM < (1 << CW) - 1) errM++;
      end
    end
    #1;
    checkAll();
  endtask

  task automatic setReq(input logic [2:0] t, input logic [31:0] im,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] f3, input logic [4:0] d,
                        input logic [6:0] op);
    Imm_Type = t;
    imm      = im;
    rs1      = s1;
    rs2      = s2;
    funct3   = f3;
    rd       = d;
    opcode   = op;
  endtask

  int bnd[13] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                  1048574, 1048576, -1048576, -1048578, 0};

  initial begin
    tests = 0;
    fails = 0;
    errM  = 0;
    reset = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    setReq(3'd0, 32'h0, 5'd0, 5'd0, 3'd0, 5'd0, 7'd0);
    step();
    step();
    reset = 1'b0;
    step();

    setReq(3'd0, 32'hFFFF_FFFF, 5'd5, 5'd0, 3'd0, 5'd1, 7'b0010011);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("I_vec", out_inst, 32'hFFF28093);
    out_ready = 1'b1;
    step();

    setReq(3'd3, 32'hFFFF_FFFC, 5'd1, 5'd2, 3'b001, 5'd0, 7'b1100011);
    in_valid = 1'b1;
    step();
    chk("B_vec", out_inst, 32'hFE209EE3);
    setReq(3'd1, 32'd3, 5'd0, 5'd0, 3'd0, 5'd7, 7'b1101111);
    step();
    chk("J_odd_err", {31'b0, out_err}, 32'd1);
    chk("J_odd_cnt", {{(32-CW){1'b0}}, err_cnt}, 32'd1);
    setReq(3'd4, 32'h1234_5000, 5'd0, 5'd0, 3'd0, 5'd10, 7'b0110111);
    step();
    chk("U_vec", out_inst, 32'h12345537);
    in_valid = 1'b0;
    step();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setReq(3'd0, 32'(i + 1), 5'(i), 5'd0, 3'd0, 5'(i + 4), 7'b0010011);
      step();
    end
    chk("full_block", {31'b0, in_ready}, 32'd0);
    setReq(3'd2, 32'd100, 5'd3, 5'd4, 3'd2, 5'd0, 7'b0100011);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    setReq(3'b110, 32'h1234_5678, 5'd1, 5'd2, 3'd3, 5'd4, 7'h33);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    step();
    chk("illegal_inst", out_inst, 32'h0);
    chk("illegal_err", {31'b0, out_err}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", {{(32-CW){1'b0}}, err_cnt}, 32'((1 << CW) - 1));

    out_ready = 1'b0;
    setReq(3'd0, 32'd5, 5'd1, 5'd0, 3'd0, 5'd2, 7'h13);
    step();
    step();
    reset = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_cnt", {{(32-CW){1'b0}}, err_cnt}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] im;
      case ($urandom_range(0, 3))
        0: im = $urandom;
        1: im = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: im = bnd[$urandom_range(0, 12)];
        default: im = $urandom & 32'hFFFF_F000;
      endcase
      setReq(3'($urandom_range(0, 7)), im, 5'($urandom), 5'($urandom),
             3'($urandom), 5'($urandom), 7'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
